// File: rtl/fe_capture_pkt.sv
// fe_capture_pkt: USB front-end capture engine packing rxvalid/status events into DATA/STAT/TIME packets.
// Optional FE_CAPTURE_DROP_COUNT_EN: O_drop_count counts dropped events; otherwise the port is tied to 0.
`ifndef FE_FIFO_CMD_DATA
`define FE_FIFO_CMD_DATA 2'd0
`endif
`ifndef FE_FIFO_CMD_STAT
`define FE_FIFO_CMD_STAT 2'd1
`endif
`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'd2
`endif
module fe_capture_pkt #(
    parameter int pDATA_WIDTH     = 8,
    parameter int pSTATUS_BITS    = 5,
    parameter int pTS_WIDTH       = 16,
    parameter int pSHORT_TS_WIDTH = 3,
    parameter int pQUEUE_DEPTH    = 8,
    parameter int pCOUNT_WIDTH    = 16
) (
    input  logic                    fe_clk,
    input  logic                    reset_i,
    input  logic [pDATA_WIDTH-1:0]  fe_data,
    input  logic                    fe_rxvalid,
    input  logic [pSTATUS_BITS-1:0] fe_status,
    input  logic                    I_arm,
    input  logic                    I_capture_enable,
    input  logic [pCOUNT_WIDTH-1:0] I_capture_len,
    input  logic                    I_continuous,
    input  logic                    I_timestamps_disable,
    input  logic                    I_ready,
    output logic                    O_valid,
    output logic [1:0]              O_command,
    output logic [pDATA_WIDTH-1:0]  O_data,
    output logic [pSTATUS_BITS-1:0] O_status,
    output logic [pTS_WIDTH-1:0]    O_time,
    output logic                    O_capturing,
    output logic                    O_overflow,
    output logic [15:0]             O_drop_count
);
    localparam int AW = $clog2(pQUEUE_DEPTH);
    localparam int EW = 2 + pDATA_WIDTH + pSTATUS_BITS + pTS_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_TIME, S_EVT} state_t;

    logic [2:0]              arm_q;
    logic [pCOUNT_WIDTH-1:0] len_meta_q, len_q;
    logic [1:0]              cont_q;
    logic [pSTATUS_BITS-1:0] status_prev_q, s1_status_q;
    logic                    s1_ev_q;
    logic [1:0]              s1_kind_q;
    logic [pDATA_WIDTH-1:0]  s1_data_q;
    logic                    ts_run_q, ts_run_d, roll;
    logic [pTS_WIDTH-1:0]    ts_q, ts_d;
    logic [AW:0]             wr_q, rd_q;
    logic [EW-1:0]           mem_q [pQUEUE_DEPTH];
    logic [pCOUNT_WIDTH-1:0] pkt_q, pkt_d;
    logic                    ovf_q, ovf_d;
    state_t                  state_q, state_d, eff;
    logic                    arm_edge, ev, capture_allowed, push_req, full, empty;
    logic                    hs, pop, do_push, drop, split;
    logic [EW-1:0]           entry;
    logic [1:0]              h_kind;
    logic [pDATA_WIDTH-1:0]  h_data;
    logic [pSTATUS_BITS-1:0] h_status;
    logic [pTS_WIDTH-1:0]    h_ts;

    assign arm_edge        = arm_q[1] & ~arm_q[2];
    assign ev              = fe_rxvalid | (fe_status != status_prev_q);
    assign capture_allowed = I_capture_enable & (cont_q[1] | (pkt_q < len_q)) & ~ovf_q;

    // Two-flop synchronisers for the quasi-static controls plus arm edge detect
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            arm_q      <= '0;
            len_meta_q <= '0;
            len_q      <= '0;
            cont_q     <= '0;
        end else begin
            arm_q      <= {arm_q[1:0], I_arm};
            len_meta_q <= I_capture_len;
            len_q      <= len_meta_q;
            cont_q     <= {cont_q[0], I_continuous};
        end
    end

    // Stage-1 event capture; s1_data_q keeps the last received byte for non-DATA packets
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            status_prev_q <= '0;
            s1_ev_q       <= 1'b0;
            s1_kind_q     <= `FE_FIFO_CMD_DATA;
            s1_data_q     <= '0;
            s1_status_q   <= '0;
        end else begin
            status_prev_q <= fe_status;
            s1_ev_q       <= ev;
            s1_kind_q     <= fe_rxvalid ? `FE_FIFO_CMD_DATA : `FE_FIFO_CMD_STAT;
            s1_data_q     <= fe_rxvalid ? fe_data : s1_data_q;
            s1_status_q   <= fe_status;
        end
    end

    // Timestamp counter: starts on the first enabled event, clears on each event or rollover
    always_comb begin
        roll     = ts_run_q & I_capture_enable & ~s1_ev_q & (&ts_q);
        ts_run_d = I_capture_enable & (ts_run_q | s1_ev_q);
        ts_d     = (~I_capture_enable | ~ts_run_q | s1_ev_q | roll) ? '0 : ts_q + pTS_WIDTH'(1);
    end

    // Timestamp counter state
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            ts_run_q <= 1'b0;
            ts_q     <= '0;
        end else begin
            ts_run_q <= ts_run_d;
            ts_q     <= ts_d;
        end
    end

    assign push_req = capture_allowed & (s1_ev_q | (roll & ~I_timestamps_disable));
    assign entry    = {s1_ev_q ? s1_kind_q : `FE_FIFO_CMD_TIME, s1_data_q, s1_status_q, ts_q};
    assign full     = (wr_q - rd_q) == (AW+1)'(pQUEUE_DEPTH);
    assign empty    = wr_q == rd_q;
    assign {h_kind, h_data, h_status, h_ts} = mem_q[rd_q[AW-1:0]];
    assign split    = ~I_timestamps_disable & (h_kind != `FE_FIFO_CMD_TIME) & ((h_ts >> pSHORT_TS_WIDTH) != '0);
    assign eff      = empty ? S_IDLE : (state_q == S_IDLE) ? (split ? S_TIME : S_EVT) : state_q;
    assign hs       = ~empty & I_ready;
    assign pop      = hs & (eff == S_EVT);
    assign do_push  = push_req & (~full | pop) & ~arm_edge;
    assign drop     = push_req & full & ~pop & ~arm_edge;

    // Queue storage; contents beyond the pointers are never observed so no reset is needed
    always_ff @(posedge fe_clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= entry;
    end

    // Queue pointers; an arm edge flushes and takes priority over a coincident push
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (arm_edge) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(pop);
        end
    end

    // Handshake counter (saturating) and sticky overflow, both cleared by arm
    always_comb begin
        pkt_d = arm_edge ? '0 : (hs & ~&pkt_q) ? pkt_q + pCOUNT_WIDTH'(1) : pkt_q;
        ovf_d = ~arm_edge & (ovf_q | drop);
    end

    // Counter and overflow state
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            pkt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pkt_q <= pkt_d;
            ovf_q <= ovf_d;
        end
    end

    // Output FSM state register
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state: split heads go TIME then EVT; an EVT handshake pops and returns to idle
    always_comb begin
        state_d = (arm_edge | empty) ? S_IDLE : hs ? ((eff == S_TIME) ? S_EVT : S_IDLE) : eff;
    end

    // Packet outputs decoded from queue head and effective phase; zero when nothing is presented
    always_comb begin
        O_valid     = ~empty;
        O_command   = empty ? 2'd0 : (eff == S_TIME) ? `FE_FIFO_CMD_TIME : h_kind;
        O_data      = empty ? '0 : h_data;
        O_status    = empty ? '0 : h_status;
        O_time      = (empty | ((eff == S_EVT) & (split | I_timestamps_disable))) ? '0 : h_ts;
        O_capturing = capture_allowed;
        O_overflow  = ovf_q;
    end

`ifdef FE_CAPTURE_DROP_COUNT_EN
    logic [15:0] drop_q;

    // Saturating dropped-event counter, cleared on arm
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i)                drop_q <= '0;
        else if (arm_edge)          drop_q <= '0;
        else if (drop & ~&drop_q)   drop_q <= drop_q + 16'd1;
    end

    assign O_drop_count = drop_q;
`else
    assign O_drop_count = '0;
`endif

endmodule
